// File: rtl/l15_port_arbiter_if.sv
// One L1.5 transducer-style port: request fields toward the L1.5, ack and response back.
// The requester side uses the master modport and the L1.5 side uses the slave modport.
interface l15_port_arbiter_if;
  logic [4:0]  rqtype;
  logic [2:0]  size;
  logic [31:0] address;
  logic [31:0] data;
  logic        req_val;
  logic        ack;
  logic        header_ack;
  logic        resp_val;
  logic [63:0] data_0;
  logic [63:0] data_1;
  logic [3:0]  returntype;
  logic        req_ack;

  modport master (
    output rqtype, size, address, data, req_val, req_ack,
    input  ack, header_ack, resp_val, data_0, data_1, returntype
  );

  modport slave (
    input  rqtype, size, address, data, req_val, req_ack,
    output ack, header_ack, resp_val, data_0, data_1, returntype
  );
endinterface

// File: rtl/l15_port_arbiter.sv
// Shares one L1.5 transducer port between the fetch unit (instr) and the load/store unit (mem),
// with a single transaction outstanding and a bounded run of mem grants while fetch waits.
module l15_port_arbiter #(
  parameter int unsigned MEM_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  l15_port_arbiter_if.slave        instr,
  l15_port_arbiter_if.slave        mem,
  l15_port_arbiter_if.master       l15,
  output logic                     owner_mem,
  output logic                     err_timeout,
  output logic [7:0]               drop_cnt
);

  localparam int BW = $clog2(MEM_BURST_MAX + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [31:0]   wdog_q, wdog_d;
  logic          err_q, err_d;
  logic [7:0]    drop_q, drop_d;

  logic burst_full_s;
  logic owner_req_ack_s;
  logic unsolicited_s;

  assign burst_full_s    = (burst_q == BW'(MEM_BURST_MAX));
  assign owner_req_ack_s = owner_q ? mem.req_ack : instr.req_ack;
  // Any response outside RESP was not asked for by the current owner, so it is swallowed.
  assign unsolicited_s   = l15.resp_val && (state_q != ST_RESP);

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      burst_q <= '0;
      wdog_q  <= 32'd0;
      err_q   <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state: grant selection, transaction progress, watchdog and drop counting.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    drop_d  = drop_q;

    if (unsolicited_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (mem.req_val && !(instr.req_val && burst_full_s)) begin
          state_d = ST_REQ;
          owner_d = 1'b1;
          burst_d = instr.req_val ? (burst_q + BW'(1)) : '0;
        end else if (instr.req_val) begin
          state_d = ST_REQ;
          owner_d = 1'b0;
          burst_d = '0;
        end else begin
          burst_d = '0;
        end
      end
      ST_REQ: begin
        wdog_d = 32'd0;
        if (l15.ack) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (l15.resp_val && owner_req_ack_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
        // Watchdog only flags the stall; the transaction is left waiting for its response.
        if ((TIMEOUT_CYC != 32'd0) && (wdog_q != 32'(TIMEOUT_CYC))) begin
          wdog_d = wdog_q + 32'd1;
          if (wdog_q == 32'(TIMEOUT_CYC) - 32'd1) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          wdog_d = wdog_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Port routing: owner's request to the L1.5, acks and responses back to the owner only.
  always_comb begin
    l15.rqtype   = 5'd0;
    l15.size     = 3'd0;
    l15.address  = 32'd0;
    l15.data     = 32'd0;
    l15.req_val  = 1'b0;
    l15.req_ack  = 1'b0;

    instr.ack        = 1'b0;
    instr.header_ack = 1'b0;
    instr.resp_val   = 1'b0;
    instr.data_0     = l15.data_0;
    instr.data_1     = l15.data_1;
    instr.returntype = l15.returntype;
    mem.ack          = 1'b0;
    mem.header_ack   = 1'b0;
    mem.resp_val     = 1'b0;
    mem.data_0       = l15.data_0;
    mem.data_1       = l15.data_1;
    mem.returntype   = l15.returntype;

    if (state_q == ST_REQ) begin
      if (owner_q) begin
        l15.rqtype     = mem.rqtype;
        l15.size       = mem.size;
        l15.address    = mem.address;
        l15.data       = mem.data;
        l15.req_val    = mem.req_val;
        mem.ack        = l15.ack;
        mem.header_ack = l15.header_ack;
      end else begin
        l15.rqtype       = instr.rqtype;
        l15.size         = instr.size;
        l15.address      = instr.address;
        l15.data         = instr.data;
        l15.req_val      = instr.req_val;
        instr.ack        = l15.ack;
        instr.header_ack = l15.header_ack;
      end
    end else begin
      l15.req_val = 1'b0;
    end

    if (state_q == ST_RESP) begin
      l15.req_ack    = owner_req_ack_s;
      mem.resp_val   = owner_q && l15.resp_val;
      instr.resp_val = !owner_q && l15.resp_val;
    end else begin
      l15.req_ack = unsolicited_s;
    end
  end

  assign owner_mem   = (state_q != ST_IDLE) && owner_q;
  assign err_timeout = err_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_l15_port_arbiter.sv
// Directed bench for l15_port_arbiter: each task drives one scenario and checks against
// hand-computed values (MEM_BURST_MAX=4, TIMEOUT_CYC=16).
module tb_l15_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       owner_mem;
  logic       err_timeout;
  logic [7:0] drop_cnt;
  int         n_chk  = 0;
  int         n_fail = 0;

  l15_port_arbiter_if instr_if ();
  l15_port_arbiter_if mem_if ();
  l15_port_arbiter_if l15_if ();

  l15_port_arbiter #(
    .MEM_BURST_MAX(4),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr_if),
    .mem        (mem_if),
    .l15        (l15_if),
    .owner_mem  (owner_mem),
    .err_timeout(err_timeout),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    instr_if.rqtype = 5'd0;  instr_if.size = 3'd0;  instr_if.address = 32'd0;
    instr_if.data = 32'd0;   instr_if.req_val = 1'b0; instr_if.req_ack = 1'b0;
    mem_if.rqtype = 5'd0;    mem_if.size = 3'd0;    mem_if.address = 32'd0;
    mem_if.data = 32'd0;     mem_if.req_val = 1'b0;   mem_if.req_ack = 1'b0;
    l15_if.ack = 1'b0;       l15_if.header_ack = 1'b0; l15_if.resp_val = 1'b0;
    l15_if.data_0 = 64'd0;   l15_if.data_1 = 64'd0;   l15_if.returntype = 4'd0;
  endtask

  task automatic test_reset();
    init_inputs();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    n_chk++; if (owner_mem !== 1'b0) begin n_fail++; $display("FAIL reset_owner_mem: got %0h want 0", owner_mem); end
    n_chk++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err_timeout); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_chk++; if ({l15_if.req_val, l15_if.req_ack, l15_if.address} !== 34'd0) begin
      n_fail++; $display("FAIL reset_l15_out: got val=%0h rack=%0h addr=%0h want 0", l15_if.req_val, l15_if.req_ack, l15_if.address); end
    n_chk++; if ({instr_if.resp_val, instr_if.ack, mem_if.resp_val, mem_if.ack} !== 4'd0) begin
      n_fail++; $display("FAIL reset_req_out: got %b want 0000", {instr_if.resp_val, instr_if.ack, mem_if.resp_val, mem_if.ack}); end
  endtask

  task automatic test_instr_only();
    // c0: IDLE, request raised; grant takes one cycle
    instr_if.req_val = 1'b1; instr_if.address = 32'h1000; instr_if.rqtype = 5'h10; instr_if.size = 3'd3;
    #1;
    n_chk++; if (l15_if.req_val !== 1'b0) begin n_fail++; $display("FAIL io_grant_latency: got %0h want 0", l15_if.req_val); end
    cyc(); // c1 REQ
    n_chk++; if (l15_if.req_val !== 1'b1) begin n_fail++; $display("FAIL io_req_val: got %0h want 1", l15_if.req_val); end
    n_chk++; if (l15_if.address !== 32'h1000) begin n_fail++; $display("FAIL io_req_addr: got %0h want 1000", l15_if.address); end
    n_chk++; if (l15_if.rqtype !== 5'h10) begin n_fail++; $display("FAIL io_req_type: got %0h want 10", l15_if.rqtype); end
    n_chk++; if (owner_mem !== 1'b0) begin n_fail++; $display("FAIL io_owner: got %0h want 0", owner_mem); end
    cyc(); // c2 header ack
    l15_if.header_ack = 1'b1;
    #1;
    n_chk++; if ({instr_if.header_ack, mem_if.header_ack} !== 2'b10) begin
      n_fail++; $display("FAIL io_header_ack: got %b want 10", {instr_if.header_ack, mem_if.header_ack}); end
    cyc(); // c3 ack
    l15_if.header_ack = 1'b0; l15_if.ack = 1'b1;
    #1;
    n_chk++; if ({instr_if.ack, mem_if.ack} !== 2'b10) begin
      n_fail++; $display("FAIL io_ack: got %b want 10", {instr_if.ack, mem_if.ack}); end
    cyc(); // c4 RESP
    l15_if.ack = 1'b0; instr_if.req_val = 1'b0;
    #1;
    n_chk++; if (l15_if.req_val !== 1'b0) begin n_fail++; $display("FAIL io_val_drop: got %0h want 0", l15_if.req_val); end
    cyc(); // c5
    cyc(); // c6 response
    l15_if.resp_val = 1'b1; l15_if.data_0 = 64'hDEAD_BEEF; l15_if.returntype = 4'h2; instr_if.req_ack = 1'b1;
    #1;
    n_chk++; if (instr_if.resp_val !== 1'b1) begin n_fail++; $display("FAIL io_resp_val: got %0h want 1", instr_if.resp_val); end
    n_chk++; if (instr_if.data_0 !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL io_resp_data: got %0h want deadbeef", instr_if.data_0); end
    n_chk++; if (instr_if.returntype !== 4'h2) begin n_fail++; $display("FAIL io_resp_type: got %0h want 2", instr_if.returntype); end
    n_chk++; if (mem_if.resp_val !== 1'b0) begin n_fail++; $display("FAIL io_mem_resp: got %0h want 0", mem_if.resp_val); end
    n_chk++; if (l15_if.req_ack !== 1'b1) begin n_fail++; $display("FAIL io_req_ack: got %0h want 1", l15_if.req_ack); end
    cyc(); // c7 IDLE
    l15_if.resp_val = 1'b0; instr_if.req_ack = 1'b0;
    #1;
    n_chk++; if ({instr_if.resp_val, l15_if.req_ack, drop_cnt} !== 10'd0) begin
      n_fail++; $display("FAIL io_idle: got resp=%0h rack=%0h drop=%0d want 0", instr_if.resp_val, l15_if.req_ack, drop_cnt); end
  endtask

  task automatic test_grant_order();
    logic [9:0] exp_mem;
    logic [31:0] exp_addr;
    exp_mem = 10'b01111_01111;
    instr_if.req_val = 1'b1; instr_if.address = 32'h1000; instr_if.req_ack = 1'b1;
    mem_if.req_val = 1'b1;   mem_if.address = 32'h3000;   mem_if.req_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(); // REQ
      exp_addr = exp_mem[k] ? 32'h3000 : 32'h1000;
      n_chk++; if (owner_mem !== exp_mem[k]) begin n_fail++; $display("FAIL order_owner[%0d]: got %0h want %0h", k, owner_mem, exp_mem[k]); end
      n_chk++; if (l15_if.address !== exp_addr) begin n_fail++; $display("FAIL order_addr[%0d]: got %0h want %0h", k, l15_if.address, exp_addr); end
      l15_if.ack = 1'b1;
      #1;
      n_chk++; if ({mem_if.ack, instr_if.ack} !== {exp_mem[k], ~exp_mem[k]}) begin
        n_fail++; $display("FAIL order_ack[%0d]: got %b want %b", k, {mem_if.ack, instr_if.ack}, {exp_mem[k], ~exp_mem[k]}); end
      cyc(); // RESP
      l15_if.ack = 1'b0; l15_if.resp_val = 1'b1;
      cyc(); // IDLE
      l15_if.resp_val = 1'b0;
    end
    instr_if.req_val = 1'b0; instr_if.req_ack = 1'b0;
    mem_if.req_val = 1'b0;   mem_if.req_ack = 1'b0;
    cyc();
  endtask

  task automatic test_mem_during_instr();
    instr_if.req_val = 1'b1; instr_if.address = 32'h1000;
    cyc(); // REQ
    l15_if.ack = 1'b1;
    cyc(); // RESP (instr)
    l15_if.ack = 1'b0; instr_if.req_val = 1'b0;
    mem_if.req_val = 1'b1; mem_if.address = 32'h2000; mem_if.data = 32'h55; mem_if.rqtype = 5'h01;
    #1;
    n_chk++; if ({owner_mem, l15_if.req_val} !== 2'b00) begin n_fail++; $display("FAIL mdi_hold0: got %b want 00", {owner_mem, l15_if.req_val}); end
    cyc();
    n_chk++; if (owner_mem !== 1'b0) begin n_fail++; $display("FAIL mdi_hold1: got %0h want 0", owner_mem); end
    l15_if.resp_val = 1'b1; l15_if.data_1 = 64'h0123_4567_89AB_CDEF; instr_if.req_ack = 1'b1;
    #1;
    n_chk++; if ({instr_if.resp_val, mem_if.resp_val} !== 2'b10) begin
      n_fail++; $display("FAIL mdi_instr_resp: got %b want 10", {instr_if.resp_val, mem_if.resp_val}); end
    cyc(); // IDLE: mem grant cycle
    l15_if.resp_val = 1'b0; instr_if.req_ack = 1'b0;
    #1;
    n_chk++; if ({owner_mem, l15_if.req_val} !== 2'b00) begin n_fail++; $display("FAIL mdi_grant_cycle: got %b want 00", {owner_mem, l15_if.req_val}); end
    cyc(); // REQ (mem)
    n_chk++; if (owner_mem !== 1'b1) begin n_fail++; $display("FAIL mdi_owner_rise: got %0h want 1", owner_mem); end
    n_chk++; if ({l15_if.address, l15_if.data} !== {32'h2000, 32'h55}) begin
      n_fail++; $display("FAIL mdi_store_fields: got %0h/%0h want 2000/55", l15_if.address, l15_if.data); end
    l15_if.ack = 1'b1;
    #1;
    n_chk++; if ({mem_if.ack, instr_if.ack} !== 2'b10) begin n_fail++; $display("FAIL mdi_mem_ack: got %b want 10", {mem_if.ack, instr_if.ack}); end
    cyc(); // RESP (mem)
    l15_if.ack = 1'b0; mem_if.req_val = 1'b0;
    l15_if.resp_val = 1'b1; mem_if.req_ack = 1'b1;
    #1;
    n_chk++; if ({mem_if.resp_val, instr_if.resp_val} !== 2'b10) begin
      n_fail++; $display("FAIL mdi_mem_resp: got %b want 10", {mem_if.resp_val, instr_if.resp_val}); end
    n_chk++; if (mem_if.data_1 !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL mdi_mem_data1: got %0h want 123456789abcdef", mem_if.data_1); end
    cyc(); // IDLE
    l15_if.resp_val = 1'b0; mem_if.req_ack = 1'b0;
    #1;
    n_chk++; if (owner_mem !== 1'b0) begin n_fail++; $display("FAIL mdi_release: got %0h want 0", owner_mem); end
  endtask

  task automatic test_unsolicited();
    l15_if.resp_val = 1'b1;
    #1;
    n_chk++; if (l15_if.req_ack !== 1'b1) begin n_fail++; $display("FAIL uns_req_ack: got %0h want 1", l15_if.req_ack); end
    n_chk++; if ({instr_if.resp_val, mem_if.resp_val} !== 2'b00) begin
      n_fail++; $display("FAIL uns_fwd: got %b want 00", {instr_if.resp_val, mem_if.resp_val}); end
    cyc();
    l15_if.resp_val = 1'b0;
    #1;
    n_chk++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL uns_drop: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_ack_resp_same_cycle();
    instr_if.req_val = 1'b1;
    cyc(); // REQ
    l15_if.ack = 1'b1; l15_if.resp_val = 1'b1; instr_if.req_ack = 1'b1;
    #1;
    n_chk++; if ({instr_if.ack, instr_if.resp_val, l15_if.req_ack} !== 3'b101) begin
      n_fail++; $display("FAIL same_cycle: got %b want 101", {instr_if.ack, instr_if.resp_val, l15_if.req_ack}); end
    cyc(); // RESP
    l15_if.ack = 1'b0; l15_if.resp_val = 1'b0; instr_if.req_val = 1'b0;
    #1;
    n_chk++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL same_cycle_drop: got %0d want 2", drop_cnt); end
    l15_if.resp_val = 1'b1;
    #1;
    n_chk++; if (instr_if.resp_val !== 1'b1) begin n_fail++; $display("FAIL same_cycle_resp: got %0h want 1", instr_if.resp_val); end
    cyc(); // IDLE
    l15_if.resp_val = 1'b0; instr_if.req_ack = 1'b0;
    #1;
    n_chk++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL same_cycle_drop_hold: got %0d want 2", drop_cnt); end
  endtask

  task automatic test_timeout();
    instr_if.req_val = 1'b1;
    cyc(); // REQ
    l15_if.ack = 1'b1;
    cyc(); // RESP entered
    l15_if.ack = 1'b0; instr_if.req_val = 1'b0;
    repeat (15) cyc();
    n_chk++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %0h want 0", err_timeout); end
    cyc();
    n_chk++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %0h want 1", err_timeout); end
    repeat (3) cyc();
    l15_if.resp_val = 1'b1; instr_if.req_ack = 1'b1;
    #1;
    n_chk++; if (instr_if.resp_val !== 1'b1) begin n_fail++; $display("FAIL to_still_resp: got %0h want 1", instr_if.resp_val); end
    cyc(); // IDLE
    l15_if.resp_val = 1'b0; instr_if.req_ack = 1'b0;
    repeat (2) cyc();
    n_chk++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %0h want 1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    mem_if.req_val = 1'b1; mem_if.address = 32'h2000;
    cyc(); // REQ
    l15_if.ack = 1'b1;
    cyc(); // RESP (mem)
    l15_if.ack = 1'b0; mem_if.req_val = 1'b0;
    #1;
    n_chk++; if (owner_mem !== 1'b1) begin n_fail++; $display("FAIL rm_owner_before: got %0h want 1", owner_mem); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_chk++; if ({owner_mem, err_timeout, drop_cnt, l15_if.req_val} !== 11'd0) begin
      n_fail++; $display("FAIL rm_cleared: got own=%0h err=%0h drop=%0d val=%0h want 0", owner_mem, err_timeout, drop_cnt, l15_if.req_val); end
    l15_if.resp_val = 1'b1; mem_if.req_ack = 1'b1;
    #1;
    n_chk++; if ({mem_if.resp_val, l15_if.req_ack} !== 2'b01) begin
      n_fail++; $display("FAIL rm_late_resp: got %b want 01", {mem_if.resp_val, l15_if.req_ack}); end
    cyc();
    l15_if.resp_val = 1'b0; mem_if.req_ack = 1'b0;
    #1;
    n_chk++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL rm_late_drop: got %0d want 1", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_instr_only();
    test_grant_order();
    test_mem_during_instr();
    test_unsolicited();
    test_ack_resp_same_cycle();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
